// File: rtl/stg_pkg.sv
// stg_pkg: shared hit_detect defaults (coordinate/index widths, hitbox size) and scan state encoding
package stg_pkg;
  localparam int COORD_W_D = 10;
  localparam int IDX_W_D = 6;
  localparam int HIT_R_D = 4;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/hitbox_cmp.sv
// hitbox_cmp: combinational overlap test, hit iff |bx-ax|<=HIT_R and |by-ay|<=HIT_R; ports ax/ay, bx/by in, hit out
module hitbox_cmp #(
  parameter int COORD_W = 10,
  parameter int HIT_R = 4
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               hit
);
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0] adx, ady;
  always_comb begin
    dx = $signed({1'b0, bx}) - $signed({1'b0, ax});
    dy = $signed({1'b0, by}) - $signed({1'b0, ay});
    adx = dx < 0 ? -dx : dx;
    ady = dy < 0 ? -dy : dy;
    hit = adx <= (COORD_W+1)'(HIT_R) && ady <= (COORD_W+1)'(HIT_R);
  end
endmodule

// File: rtl/hit_detect.sv
// hit_detect: per-frame bullet scan vs player hitbox; ports clk/rst, frame_start, player_x/y, dead, bul_* stream in, is_hit/hit_kill/hit_idx/invuln/scan_done out (hit_count when HIT_STATS_EN defined)
module hit_detect
  import stg_pkg::*;
#(
  parameter int COORD_W = COORD_W_D,
  parameter int IDX_W = IDX_W_D,
  parameter int HIT_R = HIT_R_D,
  parameter int HOLD_CYCLES = 1000001,
  parameter int INVULN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic               dead,
  input  logic               bul_valid,
  output logic               bul_ready,
  input  logic [COORD_W-1:0] bul_x,
  input  logic [COORD_W-1:0] bul_y,
  input  logic               bul_last,
  output logic               is_hit,
  output logic               hit_kill,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               invuln,
  output logic               scan_done
`ifdef HIT_STATS_EN
  ,output logic [7:0]        hit_count
`endif
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int VW = $clog2(INVULN_FRAMES + 1);
  state_t state;
  logic [COORD_W-1:0] px, py;
  logic [IDX_W-1:0] idx, pidx;
  logic [HW-1:0] hold_cnt;
  logic [VW-1:0] inv_cnt;
  logic pending, overlap, take, hit_now;
  hitbox_cmp #(.COORD_W(COORD_W), .HIT_R(HIT_R)) u_cmp (
    .ax(px), .ay(py), .bx(bul_x), .by(bul_y), .hit(overlap)
  );
  assign bul_ready = state == SCAN;
  assign invuln = inv_cnt != '0;
  assign take = overlap && !pending && !invuln && !is_hit && !dead;
  assign hit_now = pending || take;
  // hit outputs are registered on the last transfer so they appear in the DONE cycle;
  // pending stays set into DONE where it arms the invulnerability window
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      px <= '0;
      py <= '0;
      idx <= '0;
      pidx <= '0;
      pending <= 1'b0;
      is_hit <= 1'b0;
      hold_cnt <= '0;
      inv_cnt <= '0;
      hit_kill <= 1'b0;
      hit_idx <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      hit_kill <= 1'b0;
      if (frame_start && invuln) inv_cnt <= inv_cnt - 1'b1;
      if (state == DONE && pending) inv_cnt <= VW'(INVULN_FRAMES);
      if (is_hit) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) is_hit <= 1'b0;
      end
      if (frame_start) begin
        state <= SCAN;
        px <= player_x;
        py <= player_y;
        idx <= '0;
        pending <= 1'b0;
      end else if (state == SCAN && bul_valid) begin
        idx <= idx + 1'b1;
        if (take) begin
          pending <= 1'b1;
          pidx <= idx;
        end
        if (bul_last) begin
          state <= DONE;
          scan_done <= 1'b1;
          if (hit_now) begin
            is_hit <= 1'b1;
            hold_cnt <= HW'(HOLD_CYCLES);
            hit_kill <= 1'b1;
            hit_idx <= pending ? pidx : idx;
          end
        end
      end else if (state == DONE) begin
        state <= IDLE;
        pending <= 1'b0;
      end
    end
  end
`ifdef HIT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) hit_count <= '0;
    else if (hit_kill && hit_count != 8'hff) hit_count <= hit_count + 1'b1;
  end
`endif
endmodule
